// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed/unsigned divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    // Widest operand the sign fix-up helper supports; callers size-cast the result down.
    localparam int DIV_MAX_W = 64;

    function automatic logic [DIV_MAX_W-1:0] abs_n(input logic [DIV_MAX_W-1:0] x,
                                                  input logic                 neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_restoring_step #(
    parameter int n = 8
) (
    input  logic [n:0]   rem_i,
    input  logic         bit_i,
    input  logic [n-1:0] div_i,
    output logic [n:0]   rem_o,
    output logic         q_o
);

    logic [n+1:0] shifted;
    logic [n:0]   diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {2'b00, div_i});
        // When the divisor fits the difference is below 2^(n+1), so n+1 bits suffice.
        diff    = shifted[n:0] - {1'b0, div_i};
        rem_o   = q_o ? diff : shifted[n:0];
    end

endmodule

// File: rtl/signed_or_unsigned_div_seq.sv
// Iterative restoring divider, signed or unsigned per operation, valid/ready on both sides.
//
// state | meaning
// IDLE  | up_ready high, waiting for an operation
// CALC  | one quotient bit per cycle, MSB first, n cycles
// DONE  | result held on outputs with down_valid high until down_ready
module signed_or_unsigned_div_seq
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         signed_div,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (n > 2) ? $clog2(n) : 1;

    div_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n:0]    rem_q, rem_d;
    logic [n-1:0]  dvd_q, dvd_d;
    logic [n-1:0]  dsr_q, dsr_d;
    logic [n-1:0]  a_raw_q, a_raw_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          zero_q, zero_d;
    logic          up_ready_q, up_ready_d;
    logic          down_valid_q, down_valid_d;
    logic [n-1:0]  quotient_q, quotient_d;
    logic [n-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [n:0]    step_rem;
    logic          step_q;
    logic [n-1:0]  q_final;

    div_restoring_step #(.n(n)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[n-1]),
        .div_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        dvd_d        = dvd_q;
        dsr_d        = dsr_q;
        a_raw_d      = a_raw_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        zero_d       = zero_q;
        up_ready_d   = up_ready_q;
        down_valid_d = down_valid_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        dbz_d        = dbz_q;
        q_final      = {dvd_q[n-2:0], step_q};

        case (state_q)
            IDLE: begin
                if (up_valid && up_ready_q) begin
                    state_d    = CALC;
                    up_ready_d = 1'b0;
                    cnt_d      = CW'(n - 1);
                    rem_d      = '0;
                    dvd_d      = n'(abs_n(DIV_MAX_W'(a), signed_div & a[n-1]));
                    dsr_d      = n'(abs_n(DIV_MAX_W'(b), signed_div & b[n-1]));
                    a_raw_d    = a;
                    q_neg_d    = signed_div & (a[n-1] ^ b[n-1]);
                    r_neg_d    = signed_div & a[n-1];
                    zero_d     = (b == '0);
                end
            end
            CALC: begin
                // The dividend register doubles as the quotient register as bits shift through.
                rem_d = step_rem;
                dvd_d = q_final;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d      = DONE;
                    down_valid_d = 1'b1;
                    dbz_d        = zero_q;
                    if (zero_q) begin
                        quotient_d  = '1;
                        remainder_d = a_raw_q;
                    end else begin
                        quotient_d  = n'(abs_n(DIV_MAX_W'(q_final), q_neg_q));
                        remainder_d = n'(abs_n(DIV_MAX_W'(step_rem[n-1:0]), r_neg_q));
                    end
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_d      = IDLE;
                    down_valid_d = 1'b0;
                    up_ready_d   = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                up_ready_d   = 1'b1;
                down_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            dvd_q        <= '0;
            dsr_q        <= '0;
            a_raw_q      <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            zero_q       <= 1'b0;
            up_ready_q   <= 1'b1;
            down_valid_q <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            dvd_q        <= dvd_d;
            dsr_q        <= dsr_d;
            a_raw_q      <= a_raw_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            zero_q       <= zero_d;
            up_ready_q   <= up_ready_d;
            down_valid_q <= down_valid_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            dbz_q        <= dbz_d;
        end
    end

    assign up_ready    = up_ready_q;
    assign down_valid  = down_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_or_unsigned_div_seq.sv
// Directed bench for the sequential divider: vector table plus backpressure, reset and throughput cases.
module tb_signed_or_unsigned_div_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         signed_div = 1'b0;
    logic         down_valid;
    logic         down_ready = 1'b0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sgn;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[$];

    signed_or_unsigned_div_seq #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .a           (a),
        .b           (b),
        .signed_div  (signed_div),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operation, scramble the inputs afterwards, and measure latency to down_valid.
    task automatic do_op(input vec_t v);
        int k;
        int lat;
        k = 0;
        while (!up_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check({v.name, " idle_timeout"}, 32'(k < 50), 32'd1);
        a = v.a; b = v.b; signed_div = v.sgn; up_valid = 1'b1; down_ready = 1'b0;
        @(posedge clk); #1;
        up_valid = 1'b0; a = ~v.a; b = 8'h5A; signed_div = ~v.sgn;
        lat = 0;
        while (!down_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'd8);
        check({v.name, " quotient"}, 32'(quotient), 32'(v.q));
        check({v.name, " remainder"}, 32'(remainder), 32'(v.r));
        check({v.name, " dbz"}, 32'(div_by_zero), 32'(v.dbz));
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        check({v.name, " valid_drop"}, 32'(down_valid), 32'd0);
        check({v.name, " ready_back"}, 32'(up_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [N-1:0] held_q;
        logic [N-1:0] held_r;
        int lat;
        int first_acc;
        int second_acc;

        vecs.push_back('{"u200_7",    8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0});
        vecs.push_back('{"s-7_2",     8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0});
        vecs.push_back('{"s7_-2",     8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0});
        vecs.push_back('{"s-128_-1",  8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0});
        vecs.push_back('{"u128_255",  8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0});
        vecs.push_back('{"s_dbz",     8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1});
        vecs.push_back('{"u_dbz",     8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1});
        vecs.push_back('{"s-100_7",   8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0});
        vecs.push_back('{"s-100_-7",  8'h9C, 8'hF9, 1'b1, 8'h0E, 8'hFE, 1'b0});
        vecs.push_back('{"u255_1",    8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{"s5_10",     8'h05, 8'h0A, 1'b1, 8'h00, 8'h05, 1'b0});
        vecs.push_back('{"s_dbz_neg", 8'h90, 8'h00, 1'b1, 8'hFF, 8'h90, 1'b1});

        #12;
        check("rst up_ready", 32'(up_ready), 32'd1);
        check("rst down_valid", 32'(down_valid), 32'd0);
        check("rst quotient", 32'(quotient), 32'd0);
        check("rst remainder", 32'(remainder), 32'd0);
        check("rst dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) do_op(vecs[i]);

        // Backpressure: hold the result while a new operation waits on up_valid.
        a = 8'hC8; b = 8'h07; signed_div = 1'b0; up_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h64; b = 8'h0A;
        lat = 0;
        while (!down_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("bp latency", 32'(lat), 32'd8);
        held_q = quotient;
        held_r = remainder;
        check("bp first_q", 32'(held_q), 32'h1C);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp valid_held", 32'(down_valid), 32'd1);
            check("bp up_ready_low", 32'(up_ready), 32'd0);
            check("bp q_stable", 32'(quotient), 32'(held_q));
            check("bp r_stable", 32'(remainder), 32'(held_r));
        end
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        check("bp back_idle_ready", 32'(up_ready), 32'd1);
        check("bp back_idle_valid", 32'(down_valid), 32'd0);
        @(posedge clk); #1;
        up_valid = 1'b0;
        check("bp second_accepted", 32'(up_ready), 32'd0);
        lat = 0;
        while (!down_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("bp second_latency", 32'(lat), 32'd8);
        check("bp second_q", 32'(quotient), 32'h0A);
        check("bp second_r", 32'(remainder), 32'h00);
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;

        // Reset in the middle of CALC aborts the operation.
        a = 8'hC8; b = 8'h07; signed_div = 1'b0; up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid down_valid", 32'(down_valid), 32'd0);
        check("rst_mid up_ready", 32'(up_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (down_valid) lat++;
        end
        check("rst_mid no_result", 32'(lat), 32'd0);
        check("rst_mid idle_ready", 32'(up_ready), 32'd1);
        v = '{"post_rst_u255_16", 8'hFF, 8'h10, 1'b0, 8'h0F, 8'h0F, 1'b0};
        do_op(v);

        // Throughput with both handshakes held high.
        a = 8'h10; b = 8'h03; signed_div = 1'b0; up_valid = 1'b1; down_ready = 1'b1;
        first_acc = -1;
        second_acc = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (up_ready) begin
                if (first_acc < 0) first_acc = cyc;
                else if (second_acc < 0) second_acc = cyc;
            end
        end
        up_valid = 1'b0;
        down_ready = 1'b0;
        check("tput found_two", 32'(second_acc >= 0), 32'd1);
        check("tput period", 32'(second_acc - first_acc), 32'(N + 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
